// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out change after the vending FSM dispenses a soda. The owed amount is
// taken with the dispense strobe and paid out one nickel at a time: each coin is
// an ejector pulse of PULSE_CYCLES cycles followed by a wait for the hopper exit
// sensor. If the sensor stays silent for TIMEOUT_CYCLES cycles, or the hopper is
// empty, the payout is aborted and the error is held for the front panel.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_soda         1-cycle strobe, i_change valid in the same cycle
//   i_change       nickels owed (0..7)
//   i_coin_sensed  1-cycle pulse from the hopper exit sensor (already synchronous)
//   i_hopper_empty level, hopper has no coins
//   i_err_clr      1-cycle strobe, leaves the error state
//   o_eject        ejector solenoid drive
//   o_busy         payout in progress (ejecting or waiting for a coin)
//   o_done         1-cycle pulse, payout completed in full
//   o_error        payout aborted, held until i_err_clr
//   o_drop         1-cycle pulse, an i_soda arrived while not idle and was ignored
//   o_remaining    nickels still owed
//   o_paid         nickels paid in the current or last payout
// -----------------------------------------------------------------------------
module change_dispenser #(
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_soda,
   input  logic [2:0] i_change,
   input  logic       i_coin_sensed,
   input  logic       i_hopper_empty,
   input  logic       i_err_clr,
   output logic       o_eject,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic       o_drop,
   output logic [2:0] o_remaining,
   output logic [2:0] o_paid
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EJECT = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd4;

   // The pulse counter holds the number of eject cycles still to come after the
   // current one, so loading PULSE_CYCLES-1 gives exactly PULSE_CYCLES cycles.
   localparam logic [7:0]       PULSE_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

   logic [2:0]       state, state_nxt;
   logic [7:0]       pulse_cnt, pulse_cnt_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic             pend, pend_nxt;
   logic [2:0]       rem_nxt, paid_nxt;
   logic             coin;

   function automatic logic [2:0] dec_sat(input logic [2:0] v);
      return (v == 3'd0) ? v : v - 3'd1;
   endfunction

   function automatic logic [2:0] inc_sat(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
      return (v == TMO_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_nxt     = state;
      pulse_cnt_nxt = pulse_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      pend_nxt      = pend;
      rem_nxt       = o_remaining;
      paid_nxt      = o_paid;
      // A coin that dropped while the solenoid was still energised counts
      // for the wait phase that follows.
      coin          = i_coin_sensed | pend;

      case (state)
         S_IDLE: begin
            if (i_soda) begin
               paid_nxt = 3'd0;
               pend_nxt = 1'b0;
               if (i_change == 3'd0) begin
                  state_nxt = S_DONE;
                  rem_nxt   = 3'd0;
               end else begin
                  rem_nxt = i_change;
                  if (i_hopper_empty) begin
                     state_nxt = S_ERROR;
                  end else begin
                     state_nxt     = S_EJECT;
                     pulse_cnt_nxt = PULSE_LOAD;
                  end
               end
            end
         end

         S_EJECT: begin
            if (i_coin_sensed) pend_nxt = 1'b1;
            if (pulse_cnt == 8'd0) begin
               state_nxt   = S_WAIT;
               tmo_cnt_nxt = '0;
            end else begin
               pulse_cnt_nxt = pulse_cnt - 8'd1;
            end
         end

         S_WAIT: begin
            if (coin) begin
               pend_nxt = 1'b0;
               rem_nxt  = dec_sat(o_remaining);
               paid_nxt = inc_sat(o_paid);
               if (o_remaining == 3'd1) begin
                  state_nxt = S_DONE;
               end else if (i_hopper_empty) begin
                  state_nxt = S_ERROR;
               end else begin
                  state_nxt     = S_EJECT;
                  pulse_cnt_nxt = PULSE_LOAD;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = S_ERROR;
            end else begin
               tmo_cnt_nxt = tmo_inc(tmo_cnt);
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         S_ERROR: begin
            if (i_err_clr) begin
               state_nxt = S_IDLE;
               rem_nxt   = 3'd0;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they line up with it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         pulse_cnt   <= 8'd0;
         tmo_cnt     <= '0;
         pend        <= 1'b0;
         o_remaining <= 3'd0;
         o_paid      <= 3'd0;
         o_eject     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
         o_drop      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pulse_cnt   <= pulse_cnt_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         pend        <= pend_nxt;
         o_remaining <= rem_nxt;
         o_paid      <= paid_nxt;
         o_eject     <= (state_nxt == S_EJECT);
         o_busy      <= (state_nxt == S_EJECT) || (state_nxt == S_WAIT);
         o_done      <= (state_nxt == S_DONE);
         o_error     <= (state_nxt == S_ERROR);
         o_drop      <= i_soda && (state != S_IDLE);
      end
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending FSM. Consumes the soda-dispense strobe and the change amount it produces, then drives the coin-hopper ejector to pay out that many nickels.
- Pays out one coin at a time, using the hopper's coin-out sensor as the handshake.
- Detects a jammed or empty hopper and reports it to the front panel.

Parameters:
PULSE_CYCLES, 4, width of each o_eject pulse in clock cycles (legal range 1..255)
TIMEOUT_CYCLES, 64, max cycles to wait for i_coin_sensed after a pulse ends (legal range 1..65535)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_soda  input  1  1-cycle strobe: a soda was dispensed; i_change is valid in this cycle
i_change  input  3  nickels owed (0..7), sampled only when i_soda=1 is accepted
i_coin_sensed  input  1  1-cycle pulse from hopper exit sensor, already synchronized to i_clk
i_hopper_empty  input  1  level: hopper has no coins
i_err_clr  input  1  1-cycle strobe: clears the error state
o_eject  output  1  ejector solenoid drive
o_busy  output  1  a payout is in progress
o_done  output  1  1-cycle pulse: payout completed in full
o_error  output  1  level: payout aborted; stays high until i_err_clr
o_drop  output  1  1-cycle pulse: an i_soda was ignored
o_remaining  output  3  nickels still owed
o_paid  output  3  nickels paid in the current or last payout

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state goes to IDLE.
  - o_eject, o_busy, o_done, o_error, o_drop all become 0.
  - o_remaining and o_paid become 0.
  - pulse and timeout counters become 0.
  - Reset mid-payout drops o_eject at that edge; the owed change is discarded.
- States: IDLE, EJECT, WAIT, DONE, ERROR. Encoding is free.
- IDLE:
  - i_soda=1 and i_change=0 -> DONE; o_paid=0.
  - i_soda=1, i_change!=0, i_hopper_empty=1 -> ERROR; o_remaining=i_change, o_paid=0.
  - i_soda=1, i_change!=0, i_hopper_empty=0 -> EJECT; o_remaining=i_change, o_paid=0, pulse counter loaded.
- EJECT:
  - o_eject=1 for exactly PULSE_CYCLES cycles, then -> WAIT with the timeout counter cleared.
  - An i_coin_sensed in EJECT is latched into a pending flag; WAIT consumes it on its first cycle.
- WAIT:
  - o_eject=0.
  - i_coin_sensed (or the pending flag) -> o_remaining decrements and o_paid increments, both at the next edge.
    - If o_remaining was 1 -> DONE.
    - Otherwise, if i_hopper_empty=1 -> ERROR.
    - Otherwise -> EJECT.
  - No sensor pulse for TIMEOUT_CYCLES cycles -> ERROR; counters hold.
  - Extra sensor pulses beyond the first per EJECT/WAIT round are ignored.
- DONE: lasts one cycle with o_done=1, then -> IDLE.
- ERROR:
  - o_error=1 and o_eject=0; o_remaining and o_paid hold for diagnostics.
  - i_err_clr=1 -> IDLE at the next edge; o_error=0 and o_remaining=0; o_paid holds.
- o_busy=1 in EJECT and WAIT only.
- o_drop: i_soda=1 in any state other than IDLE (including DONE and ERROR) raises o_drop for one cycle (registered) and has no other effect.
- i_coin_sensed in IDLE, DONE or ERROR is ignored.
- Latency:
  - i_soda accepted at edge N -> o_eject high for cycles N+1 .. N+PULSE_CYCLES.
  - Sensor sampled at edge M in WAIT -> counters update and the next o_eject rises at M+1.
- Arithmetic:
  - o_remaining never decrements below 0.
  - o_paid never exceeds the loaded i_change; both counters are 3-bit with no wrap.
  - Timeout counter is sized ceil(log2(TIMEOUT_CYCLES+1)) bits and saturates.
- All outputs are registered.

Test Plan:
- Reset, then i_soda with i_change=3; sensor pulses 2 cycles after each eject pulse -> three 4-cycle o_eject pulses; o_remaining steps 3,2,1,0; o_paid ends at 3; one o_done pulse; o_busy low afterwards.
- i_soda with i_change=0 -> o_done pulse on the next cycle; o_eject never rises; o_paid=0.
- i_change=2, no sensor after the first pulse (TIMEOUT_CYCLES=64) -> o_error rises 64 cycles after o_eject falls; o_remaining=2, o_paid=0; i_err_clr returns to IDLE with o_remaining=0.
- i_change=4, i_hopper_empty rises after the 2nd coin is sensed -> ERROR with o_paid=2, o_remaining=2; a later i_soda while in ERROR -> o_drop pulse, no state change.
- Sensor pulse during the 3rd cycle of EJECT, i_change=1 -> o_eject completes its 4 cycles; DONE one cycle later; o_paid=1; a second sensor pulse in WAIT is ignored.
- i_rst_n low mid-EJECT with i_change=5 -> o_eject 0 at that edge; all outputs 0; a fresh i_soda with i_change=1 after reset completes normally.
